ir_fetch_queue: RTL and testbench

Instruction fetch stage of the rv32 pipeline, directly upstream of decode. Holds the fetch PC and issues word requests to instruction memory, with up to DEPTH requests in flight. Buffers in-order responses in a small FIFO and presents one instruction plus its PC per cycle to the D-stage slot of the pipeline interface. Branch and jump redirects flush everything in flight.

---
 rtl/ir_fetch_queue_pkg.sv | 16 +
 rtl/ir_fetch_queue_if.sv | 29 ++
 rtl/ir_fetch_queue_sync_fifo.sv | 52 +++++
 rtl/ir_fetch_queue.sv | 90 +++++++++
 tb/tb_ir_fetch_queue.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ir_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: the decode NOP and
// the {instr, pc} entry carried through the fetch FIFO.
package ir_fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ir_fetch_queue_if.sv
// Fetch-stage bundle: instruction memory request/response, execute redirect,
// and the D-stage instruction slot with its stall handshake.
interface ir_fetch_queue_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/ir_fetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head is the registered oldest
// entry (no write-through bypass).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && !w_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/ir_fetch_queue.sv
// rv32 fetch stage: credit-limited word requests to imem, in-order response
// buffering, and redirect flush that discards every response still in flight.
module ir_fetch_queue
    import ir_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    ir_fetch_queue_if.master   fq
);

    localparam int CW = $clog2(DEPTH + 1);

    logic         r_run;
    logic [31:0]  r_fetch_pc;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_fifo_cnt;
    logic [CW-1:0] w_outst;
    logic [CW:0]   w_used;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wentry;
    logic [31:0]   w_pcq_head;
    logic          w_flush;
    logic          w_req_fire;
    logic          w_rsp_keep;
    logic          w_pop;
    logic          w_instr_valid;

    assign w_flush       = fq.redirect_valid;
    assign w_used        = {1'b0, w_fifo_cnt} + {1'b0, w_outst};
    // Credits cover both buffered and in-flight words, so a response always has a slot.
    assign fq.imem_req_valid = r_run && !w_flush && (w_used < (CW+1)'(DEPTH));
    assign fq.imem_req_addr  = r_fetch_pc;
    assign w_req_fire    = fq.imem_req_valid && fq.imem_req_ready;
    assign w_rsp_keep    = fq.imem_rsp_valid && !w_flush && (r_drop == '0);
    assign w_instr_valid = (w_fifo_cnt != '0);
    assign w_pop         = w_instr_valid && fq.dec_ready && !w_flush;
    assign w_wentry      = '{instr: fq.imem_rsp_data, pc: w_pcq_head};

    assign fq.instr_valid = w_instr_valid;
    assign fq.instr       = w_instr_valid ? w_head.instr : NOP_INSTR;
    assign fq.instr_pc    = w_instr_valid ? w_head.pc    : 32'h0;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_entry_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_keep),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_wentry),
        .o_count (w_fifo_cnt),
        .o_head  (w_head)
    );

    // Never flushed: stale responses still arrive and must retire their PC.
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_pop   (fq.imem_rsp_valid),
        .i_flush (1'b0),
        .i_wdata (r_fetch_pc),
        .o_count (w_outst),
        .o_head  (w_pcq_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_drop     <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_flush) begin
                r_fetch_pc <= align_word(fq.redirect_pc);
                // Every word still outstanding after this cycle is stale.
                r_drop     <= w_outst - CW'(fq.imem_rsp_valid);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (fq.imem_rsp_valid && r_drop != '0) r_drop <= r_drop - CW'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) r_drop <= w_outst);

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Randomized bench for ir_fetch_queue: latency-L memory model plus an
// expected-address / expected-PC stream model restarted on each redirect.
module tb_ir_fetch_queue;
    import ir_fetch_queue_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk;
    logic rst_n;
    ir_fetch_queue_if bus();

    ir_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mreq_t       mq[$];
    logic [31:0] cons_pc[$];
    int          cyc, lat, errs, checks;
    int          fires, consumed, vcnt, mark, first_fire, first_valid;
    logic [31:0] first_fire_addr, exp_req, exp_pc, redir_pc_now;
    bit          rdy_rand, dec_rand, dec_hi, redir_rand, redir_now;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] cons_at(input int i);
        return (cons_pc.size() > i) ? cons_pc[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = dec_hi;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 0);
        check("rst_req_addr", bus.imem_req_addr, RST_PC);
        check("rst_instr_valid", 32'(bus.instr_valid), 0);
        check("rst_instr", bus.instr, 32'h0000_0013);
        check("rst_instr_pc", bus.instr_pc, 0);
        mq.delete();
        cons_pc.delete();
        exp_req = RST_PC; exp_pc = RST_PC;
        fires = 0; consumed = 0; vcnt = 0;
        mark = 0; first_fire = -1; first_valid = -1; first_fire_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic step();
        logic        rv;
        logic [31:0] rpc;
        logic        fire;
        @(negedge clk);
        cyc++;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.dec_ready      = dec_rand ? 1'($urandom_range(0, 1)) : dec_hi;
        rv  = redir_now || (redir_rand && $urandom_range(0, 29) == 0);
        rpc = redir_now ? redir_pc_now : $urandom();
        redir_now = 1'b0;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        if (rv) begin
            mark = cyc; first_fire = -1; first_valid = -1;
            cons_pc.delete();
            check("redir_no_req", 32'(bus.imem_req_valid), 0);
        end
        if (!bus.instr_valid) begin
            check("empty_instr", bus.instr, 32'h0000_0013);
            check("empty_pc", bus.instr_pc, 0);
        end else begin
            vcnt++;
            if (first_valid < 0 && cyc > mark) first_valid = cyc;
        end
        fire = bus.imem_req_valid && bus.imem_req_ready;
        if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, exp_req);
        if (fire) begin
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
            exp_req += 32'd4;
            fires++;
            if (first_fire < 0) begin
                first_fire = cyc;
                first_fire_addr = bus.imem_req_addr;
            end
        end
        if (bus.instr_valid && bus.dec_ready && !rv) begin
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr_word", bus.instr, mem_word(bus.instr_pc));
            exp_pc += 32'd4;
            consumed++;
            cons_pc.push_back(bus.instr_pc);
        end
        if (rv) begin
            exp_req = rpc & 32'hFFFF_FFFC;
            exp_pc  = rpc & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        errs = 0; checks = 0; cyc = 0;
        rst_n = 1'b0;
        redir_now = 1'b0; redir_pc_now = '0;
        rdy_rand = 1'b0; dec_rand = 1'b0; redir_rand = 1'b0; dec_hi = 1'b1;

        // L=1, always ready: back-to-back requests, stream from cycle 3
        lat = 1;
        do_reset();
        repeat (2) step();
        check("t1_first_req_cyc", 32'(first_fire), 1);
        vcnt = 0;
        repeat (20) step();
        check("t1_first_valid_cyc", 32'(first_valid), 3);
        check("t1_valid_every_cycle", 32'(vcnt), 20);

        // decode stalled from reset: 4 requests fill the queue, then drain
        dec_hi = 1'b0;
        do_reset();
        repeat (10) step();
        check("t2_req_count", 32'(fires), 4);
        check("t2_req_valid_full", 32'(bus.imem_req_valid), 0);
        check("t2_instr_valid_full", 32'(bus.instr_valid), 1);
        dec_hi = 1'b1; fires = 0; consumed = 0;
        repeat (4) step();
        check("t2_drain_count", 32'(consumed), 4);
        check("t2_req_resume", 32'(fires > 0), 1);

        // L=3, redirect with 3 outstanding to unaligned 0x103
        lat = 3;
        do_reset();
        repeat (3) step();
        redir_now = 1'b1; redir_pc_now = 32'h0000_0103;
        step();
        repeat (12) step();
        check("t3_req_after_redir", 32'(first_fire - mark), 1);
        check("t3_req_addr", first_fire_addr, 32'h0000_0100);
        check("t3_valid_latency", 32'(first_valid - mark), 5);
        check("t3_first_pc", cons_at(0), 32'h0000_0100);

        // redirect on a response cycle, then a second redirect next cycle
        lat = 2;
        do_reset();
        repeat (8) step();
        redir_now = 1'b1; redir_pc_now = 32'h0000_0180;
        step();
        redir_now = 1'b1; redir_pc_now = 32'h0000_0200;
        step();
        repeat (20) step();
        check("t4_first_pc", cons_at(0), 32'h0000_0200);
        check("t4_second_pc", cons_at(1), 32'h0000_0204);
        check("t4_drop_zero", 32'(dut.r_drop), 0);

        // random ready, stall and redirects
        lat = 2; rdy_rand = 1'b1; dec_rand = 1'b1; redir_rand = 1'b1;
        do_reset();
        repeat (400) step();
        check("t5_progress", 32'(consumed > 40), 1);
        rdy_rand = 1'b0; dec_rand = 1'b0; redir_rand = 1'b0;

        // PC wraps past the top of the address space
        lat = 1;
        do_reset();
        repeat (4) step();
        redir_now = 1'b1; redir_pc_now = 32'hFFFF_FFFC;
        step();
        repeat (10) step();
        check("t6_pc_top", cons_at(0), 32'hFFFF_FFFC);
        check("t6_pc_wrap", cons_at(1), 32'h0000_0000);

        // reset asserted mid-stream, then fetch restarts at RESET_PC
        repeat (5) step();
        check("t7_streaming", 32'(bus.instr_valid), 1);
        do_reset();
        repeat (4) step();
        check("t7_restart_cyc", 32'(first_fire), 1);
        check("t7_restart_addr", first_fire_addr, RST_PC);
        check("t7_restart_pc", cons_at(0), RST_PC);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
